// File: rtl/ddr3_bank_tracker.sv
// ddr3_bank_tracker: per-bank open-row and timing tracker that flags DDR3 protocol violations.
module ddr3_bank_tracker #(
  parameter int BA_BITS = 3,
  parameter int ROW_BITS = 16,
  parameter int TRCD = 11,
  parameter int TRP = 11,
  parameter int TRAS = 28,
  parameter int TRFC = 160
) (
  input  logic                 ck,
  input  logic                 rst,
  input  logic                 cmd_valid,
  input  logic [3:0]           cmd,
  input  logic [BA_BITS-1:0]   ba,
  input  logic [ROW_BITS-1:0]  row,
  input  logic [BA_BITS-1:0]   q_ba,
  output logic [ROW_BITS-1:0]  q_row,
  output logic [2**BA_BITS-1:0] bank_open,
  output logic                 err_valid,
  output logic [3:0]           err_code,
  output logic [BA_BITS-1:0]   err_ba
);
  localparam int NB = 2**BA_BITS;
  logic [ROW_BITS-1:0] rows [NB];
  logic [7:0] cnt [NB];
  logic [7:0] ref_cnt;
  logic chk, is_act, is_pre, is_prea, is_ap, is_rw, is_unk, needs_idle, lock, cur_open, prea_hit;
  logic [8:0] k_b;
  logic [BA_BITS-1:0] prea_ba, code_ba;
  logic [3:0] code;
  // A counter holding c at cycle t+k means k = c + 1 cycles have elapsed since the event.
  always_comb begin
    chk = cmd_valid && cmd > 4'd1;
    is_act = cmd == 4'd6;
    is_pre = cmd == 4'd4;
    is_prea = cmd == 4'd5;
    is_ap = cmd == 4'd8 || cmd == 4'd10;
    is_rw = cmd >= 4'd7 && cmd <= 4'd10;
    is_unk = cmd == 4'd15;
    needs_idle = cmd == 4'd2 || cmd == 4'd3 || (cmd >= 4'd11 && cmd <= 4'd13);
    lock = {1'b0, ref_cnt} + 9'd1 < 9'(TRFC);
    cur_open = bank_open[ba];
    k_b = {1'b0, cnt[ba]} + 9'd1;
    prea_hit = 1'b0;
    prea_ba = '0;
    for (int j = NB - 1; j >= 0; j--)
      if (bank_open[j] && {1'b0, cnt[j]} + 9'd1 < 9'(TRAS)) begin
        prea_hit = 1'b1;
        prea_ba = BA_BITS'(j);
      end
    code = !chk ? 4'd0 :
           lock ? 4'd1 :
           is_unk ? 4'd2 :
           (is_act && cur_open) ? 4'd3 :
           (is_act && k_b < 9'(TRP)) ? 4'd4 :
           (is_rw && !cur_open) ? 4'd5 :
           (is_rw && k_b < 9'(TRCD)) ? 4'd6 :
           ((is_pre && cur_open && k_b < 9'(TRAS)) || (is_prea && prea_hit)) ? 4'd7 :
           (needs_idle && |bank_open) ? 4'd8 : 4'd0;
    code_ba = (code == 4'd7 && is_prea) ? prea_ba : code == 4'd8 ? '0 : ba;
  end
  assign q_row = bank_open[q_ba] ? rows[q_ba] : '0;
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      bank_open <= '0;
      ref_cnt <= 8'hff;
      err_valid <= 1'b0;
      err_code <= '0;
      err_ba <= '0;
      for (int j = 0; j < NB; j++) begin
        rows[j] <= '0;
        cnt[j] <= 8'hff;
      end
    end else begin
      err_valid <= code != 4'd0;
      err_code <= code;
      err_ba <= code_ba;
      ref_cnt <= (chk && cmd == 4'd3) ? 8'd0 : ref_cnt + 8'(ref_cnt != 8'hff);
      for (int j = 0; j < NB; j++) begin
        if (chk && is_act && ba == BA_BITS'(j)) begin
          bank_open[j] <= 1'b1;
          rows[j] <= row;
          cnt[j] <= 8'd0;
        end else if (chk && bank_open[j] && (is_prea || (ba == BA_BITS'(j) && (is_pre || is_ap)))) begin
          bank_open[j] <= 1'b0;
          cnt[j] <= 8'd0;
        end else begin
          cnt[j] <= cnt[j] + 8'(cnt[j] != 8'hff);
        end
      end
    end
  end
endmodule

// File: tb/tb_ddr3_bank_tracker.sv
// tb_ddr3_bank_tracker: directed and randomized checks against an event-time reference model.
module tb_ddr3_bank_tracker;
  localparam int TRCD = 11, TRP = 11, TRAS = 28, TRFC = 160;
  logic ck = 0, rst = 1, cmd_valid = 0;
  logic [3:0] cmd = 0;
  logic [2:0] ba = 0, q_ba = 0, err_ba;
  logic [15:0] row = 0, q_row;
  logic [7:0] bank_open;
  logic err_valid;
  logic [3:0] err_code;
  int checks = 0, failures = 0;
  int cyc = 0;
  // Reference model: open flags, rows and the absolute cycle of each bank's last ACT/PRE.
  bit open_m [8];
  logic [15:0] row_m [8];
  int ev_t [8];
  int ref_t;
  bit exp_v;
  logic [3:0] exp_c;
  logic [2:0] exp_b;
  ddr3_bank_tracker #(.BA_BITS(3), .ROW_BITS(16), .TRCD(TRCD), .TRP(TRP), .TRAS(TRAS), .TRFC(TRFC)) dut (
    .ck(ck), .rst(rst), .cmd_valid(cmd_valid), .cmd(cmd), .ba(ba), .row(row), .q_ba(q_ba),
    .q_row(q_row), .bank_open(bank_open), .err_valid(err_valid), .err_code(err_code), .err_ba(err_ba));
  always #5 ck = ~ck;
  function automatic logic [7:0] open_vec();
    logic [7:0] v = '0;
    for (int j = 0; j < 8; j++) v[j] = open_m[j];
    return v;
  endfunction
  task automatic model_reset();
    for (int j = 0; j < 8; j++) begin
      open_m[j] = 0;
      row_m[j] = 0;
      ev_t[j] = -1000;
    end
    ref_t = -1000;
  endtask
  task automatic do_reset();
    rst = 1;
    cmd_valid = 0;
    @(posedge ck); #1;
    cyc++;
    rst = 0;
    model_reset();
  endtask
  // Drives one cycle and leaves the predicted error outputs in exp_v/exp_c/exp_b.
  task automatic issue(input bit v, input logic [3:0] c, input logic [2:0] b, input logic [15:0] r);
    int kr, kb, low;
    bit any;
    cmd_valid = v; cmd = c; ba = b; row = r;
    kr = cyc - ref_t;
    kb = cyc - ev_t[b];
    low = -1;
    any = 0;
    for (int j = 7; j >= 0; j--) begin
      if (open_m[j]) any = 1;
      if (open_m[j] && cyc - ev_t[j] < TRAS) low = j;
    end
    exp_c = 0;
    exp_b = b;
    if (v && c > 1) begin
      if (kr < TRFC) exp_c = 1;
      else if (c == 15) exp_c = 2;
      else if (c == 6 && open_m[b]) exp_c = 3;
      else if (c == 6 && kb < TRP) exp_c = 4;
      else if (c >= 7 && c <= 10 && !open_m[b]) exp_c = 5;
      else if (c >= 7 && c <= 10 && kb < TRCD) exp_c = 6;
      else if (c == 4 && open_m[b] && kb < TRAS) exp_c = 7;
      else if (c == 5 && low >= 0) begin exp_c = 7; exp_b = 3'(low); end
      else if ((c == 2 || c == 3 || c == 11 || c == 12 || c == 13) && any) begin exp_c = 8; exp_b = 0; end
    end
    exp_v = exp_c != 0;
    if (v && c > 1 && c != 15) begin
      if (c == 6) begin open_m[b] = 1; row_m[b] = r; ev_t[b] = cyc; end
      else if ((c == 4 || c == 8 || c == 10) && open_m[b]) begin open_m[b] = 0; ev_t[b] = cyc; end
      else if (c == 5) begin
        for (int j = 0; j < 8; j++) if (open_m[j]) begin open_m[j] = 0; ev_t[j] = cyc; end
      end else if (c == 3) ref_t = cyc;
    end
    @(posedge ck); #1;
    cyc++;
    cmd_valid = 0;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) issue(0, 0, 0, 0);
  endtask
  task automatic test_reset();
    rst = 1;
    #1;
    checks++;
    if (bank_open !== 8'h00 || err_valid !== 1'b0 || q_row !== 16'h0) begin
      failures++;
      $display("FAIL reset: bank_open=%h err_valid=%b q_row=%h, required 00 0 0000", bank_open, err_valid, q_row);
    end
    do_reset();
  endtask
  task automatic test_act_rd();
    do_reset();
    q_ba = 2;
    issue(1, 6, 2, 16'h1234);
    idle(10);
    issue(1, 9, 2, 0);
    checks++;
    if (err_valid !== 1'b0 || bank_open[2] !== 1'b1 || q_row !== 16'h1234) begin
      failures++;
      $display("FAIL act_rd: err_valid=%b open2=%b q_row=%h, required 0 1 1234", err_valid, bank_open[2], q_row);
    end
  endtask
  task automatic test_trcd();
    do_reset();
    issue(1, 6, 1, 16'h0042);
    idle(9);
    issue(1, 7, 1, 0);
    checks++;
    if (err_valid !== 1'b1 || err_code !== 4'd6 || err_ba !== 3'd1) begin
      failures++;
      $display("FAIL trcd: valid=%b code=%0d ba=%0d, required 1 6 1", err_valid, err_code, err_ba);
    end
  endtask
  task automatic test_tras_trp(input int gap, input bit exp_err);
    do_reset();
    issue(1, 6, 0, 16'h0007);
    idle(26);
    issue(1, 4, 0, 0);
    checks++;
    if (err_valid !== 1'b1 || err_code !== 4'd7 || err_ba !== 3'd0) begin
      failures++;
      $display("FAIL tras: valid=%b code=%0d ba=%0d, required 1 7 0", err_valid, err_code, err_ba);
    end
    idle(gap - 1);
    issue(1, 6, 0, 16'h0008);
    checks++;
    if (err_valid !== exp_err || (exp_err && err_code !== 4'd4)) begin
      failures++;
      $display("FAIL trp gap=%0d: valid=%b code=%0d, required %b 4", gap, err_valid, err_code, exp_err);
    end
  endtask
  task automatic test_ref();
    do_reset();
    issue(1, 6, 3, 16'h0033);
    idle(29);
    issue(1, 3, 0, 0);
    checks++;
    if (err_valid !== 1'b1 || err_code !== 4'd8 || err_ba !== 3'd0) begin
      failures++;
      $display("FAIL ref_open: valid=%b code=%0d ba=%0d, required 1 8 0", err_valid, err_code, err_ba);
    end
    issue(1, 5, 0, 0);
    checks++;
    if (err_valid !== exp_v || err_code !== exp_c) begin
      failures++;
      $display("FAIL prea: valid=%b code=%0d, required %b %0d", err_valid, err_code, exp_v, exp_c);
    end
    idle(10);
    issue(1, 3, 0, 0);
    idle(99);
    issue(1, 6, 4, 16'h0001);
    checks++;
    if (err_valid !== 1'b1 || err_code !== 4'd1) begin
      failures++;
      $display("FAIL trfc: valid=%b code=%0d, required 1 1", err_valid, err_code);
    end
  endtask
  task automatic test_reset_mid();
    do_reset();
    issue(1, 9, 5, 0);
    checks++;
    if (err_valid !== 1'b1 || err_code !== 4'd5 || err_ba !== 3'd5) begin
      failures++;
      $display("FAIL closed: valid=%b code=%0d ba=%0d, required 1 5 5", err_valid, err_code, err_ba);
    end
    issue(1, 6, 5, 16'h0555);
    issue(1, 9, 7, 0);
    rst = 1;
    #1;
    checks++;
    if (err_valid !== 1'b0 || bank_open !== 8'h00) begin
      failures++;
      $display("FAIL async_reset: err_valid=%b bank_open=%h, required 0 00", err_valid, bank_open);
    end
    do_reset();
    issue(1, 6, 5, 16'h0556);
    checks++;
    if (err_valid !== 1'b0 || bank_open !== 8'h20) begin
      failures++;
      $display("FAIL act_after_reset: err_valid=%b bank_open=%h, required 0 20", err_valid, bank_open);
    end
  endtask
  task automatic test_random();
    logic [3:0] pool [12] = '{6, 6, 6, 4, 4, 5, 7, 8, 9, 10, 0, 15};
    logic [3:0] c;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      c = pool[$urandom_range(0, 11)];
      if ($urandom_range(0, 199) == 0) c = 4'($urandom_range(2, 3));
      else if ($urandom_range(0, 99) == 0) c = 4'($urandom_range(11, 14));
      q_ba = 3'($urandom_range(0, 7));
      issue($urandom_range(0, 9) != 0, c, 3'($urandom_range(0, 7)), 16'($urandom));
      checks++;
      if (err_valid !== exp_v || (exp_v && err_code !== exp_c) || (exp_v && exp_c > 2 && err_ba !== exp_b)) begin
        failures++;
        $display("FAIL rand_err i=%0d cmd=%0d: valid=%b code=%0d ba=%0d, required %b %0d %0d",
                 i, c, err_valid, err_code, err_ba, exp_v, exp_c, exp_b);
      end
      checks++;
      if (bank_open !== open_vec() || q_row !== (open_m[q_ba] ? row_m[q_ba] : 16'h0)) begin
        failures++;
        $display("FAIL rand_state i=%0d: bank_open=%h q_row=%h, required %h %h",
                 i, bank_open, q_row, open_vec(), open_m[q_ba] ? row_m[q_ba] : 16'h0);
      end
    end
  endtask
  initial begin
    model_reset();
    test_reset();
    test_act_rd();
    test_trcd();
    test_tras_trp(10, 1);
    test_tras_trp(11, 0);
    test_ref();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ddr3_bank_tracker.md
DDR3_BANK_TRACKER -- requirements
Module: ddr3_bank_tracker

Interface
REQ-001 The block SHALL have parameter BA_BITS, default 3, meaning bank address width (8 banks).
REQ-002 The block SHALL have parameter ROW_BITS, default 16, meaning row address width.
REQ-003 The block SHALL have parameters TRCD, TRP, TRAS and TRFC, defaults 11, 11, 28 and 160, giving minimum clock counts for ACT->RD/WR, PRE->ACT, ACT->PRE and REF->any command.
REQ-004 The block SHALL have port ck, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port cmd_valid, input, 1 bit: qualifies cmd for the current cycle.
REQ-007 The block SHALL have port cmd, input, 4 bits: decoded command code.
- 0 NOP, 1 DES, 2 MRS, 3 REF, 4 PRE, 5 PREA, 6 ACT, 7 WR
- 8 WRAP, 9 RD, A RDAP, B ZQCL, C ZQCS, D SRE, E PDX/SRX, F UNK
REQ-008 The block SHALL have port ba, input, BA_BITS: bank address of cmd.
REQ-009 The block SHALL have port row, input, ROW_BITS: row address, used by ACT only.
REQ-010 The block SHALL have port q_ba, input, BA_BITS: bank to query.
REQ-011 The block SHALL have port q_row, output, ROW_BITS: open row of bank q_ba, combinational from registered state; 0 if that bank is closed.
REQ-012 The block SHALL have port bank_open, output, 2**BA_BITS bits: registered per-bank open flag.
REQ-013 The block SHALL have port err_valid, output, 1 bit: one-cycle violation pulse.
REQ-014 The block SHALL have port err_code, output, 4 bits: violation code, valid with err_valid.
REQ-015 The block SHALL have port err_ba, output, BA_BITS: bank of the violating command, valid with err_valid.

Function
REQ-016 The block SHALL keep, per bank, an open flag, an open-row register and an 8-bit elapsed counter; the counter loads 0 on the accepted ACT or PRE/auto-precharge for that bank and otherwise increments by 1 per cycle, saturating at 255.
REQ-017 The block SHALL keep one 8-bit refresh counter with the same rules, loaded to 0 on an accepted REF.
REQ-018 The block SHALL treat a command at cycle t+k after an event at cycle t as having elapsed count k; a constraint X is met iff k >= X.
REQ-019 The block SHALL check only commands with cmd_valid=1; NOP and DES never raise errors.
REQ-020 The block SHALL apply the checks below, reporting only the highest-priority failing one (lowest code), and SHALL register err_valid, err_code and err_ba one cycle after the command.
- 1 TRFC: any other command while refresh count < TRFC.
- 2 ILLEGAL: cmd F.
- 3 ACT_OPEN: ACT to an open bank.
- 4 TRP: ACT with count < TRP.
- 5 CLOSED: WR/WRAP/RD/RDAP to a closed bank.
- 6 TRCD: WR/WRAP/RD/RDAP with count < TRCD.
- 7 TRAS: PRE to an open bank with count < TRAS, or PREA where any open bank has count < TRAS (err_ba = lowest such bank).
- 8 ALL_OPEN: REF, MRS, ZQCL, ZQCS or SRE while any bank is open (err_ba = 0).
REQ-021 The block SHALL update state even when an error is flagged.
- ACT: set open, store row, counter 0.
- PRE to an open bank: clear open, counter 0.
- PRE to a closed bank: no state change, no error.
- PREA: PRE action on every open bank.
- WRAP/RDAP: clear open, counter 0 (auto-precharge start).
- REF: refresh counter 0.
REQ-022 The block SHALL update bank_open on the clock edge that samples the command, so it reflects the command from the next cycle.
REQ-023 The block SHALL ignore ba and row for PREA, REF, MRS, ZQ, SRE and PDX/SRX.

Reset
REQ-024 On rst=1 the block SHALL asynchronously clear bank_open, all open rows, err_valid, err_code and err_ba, and set all bank counters and the refresh counter to 255, so that no timing error can occur on the first command after reset.
REQ-025 A rst assertion mid-sequence SHALL discard all bank state and any pending error pulse.

Verification
REQ-026 ACT ba=2 row=0x1234 at t, RD ba=2 at t+11 -> bank_open[2]=1, q_row(q_ba=2)=0x1234, no error.
REQ-027 ACT ba=1 at t, WR ba=1 at t+10 -> err_valid at t+11, err_code=6, err_ba=1.
REQ-028 ACT ba=0 at t, PRE ba=0 at t+27 -> err_code=7; ACT ba=0 at t+37 -> err_code=4; ACT ba=0 at t+38 -> no error.
REQ-029 ACT ba=3, then REF 30 cycles later -> err_code=8; PREA, then REF 11 cycles later, then ACT 100 cycles after REF -> err_code=1.
REQ-030 RD ba=5 right after reset -> err_code=5; ACT ba=5, assert rst for 1 cycle, ACT ba=5 -> bank_open=0 after reset and no error on the second ACT.
